id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the MIPS core; sits directly upstream of the ALU and feeds its in1/in2/op.
//  Captures decoded operands and control, applies EX/MEM and MEM/WB forwarding, and decodes the 4-bit ALU control.
//  Detects load-use hazards and inserts one bubble; supports valid/ready backpressure and flush.
// PARAMETERS
//  DATA_W  32  operand/result width
//  REG_AW  5   register index width
//  CNT_W   16  stall counter width (IDEX_STALL_CNT_EN only)
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  rst_n          in   1       synchronous reset, active low
//  id_valid       in   1       decode presents an instruction
//  id_ready       out  1       stage accepts this cycle (combinational)
//  id_rs_data     in   DATA_W  register file rs value
//  id_rt_data     in   DATA_W  register file rt value
//  id_imm         in   DATA_W  sign-extended immediate
//  id_rs/id_rt    in   REG_AW  source indices
//  id_dest        in   REG_AW  destination index (rd/rt already selected)
//  id_uses_rt     in   1       instruction reads rt (R-type, store, branch)
//  id_alu_op      in   2       00 add, 01 sub, 10 use func
//  id_func        in   6       R-type function field
//  id_alu_src     in   1       1: in2 = immediate
//  id_reg_write/id_mem_read/id_mem_write/id_mem_to_reg  in  1 each  control bits
//  flush          in   1       kill instruction in stage (branch taken)
//  ex_ready       in   1       downstream accepts
//  mem_reg_write/mem_dest/mem_result  in  1/REG_AW/DATA_W  EX/MEM forward source
//  wb_reg_write/wb_dest/wb_data       in  1/REG_AW/DATA_W  MEM/WB forward source
//  ex_valid       out  1       stage holds valid instruction
//  ex_in1/ex_in2  out  DATA_W  ALU operands (forwarded)
//  ex_alu_ctl     out  4       ALU control code
//  ex_illegal     out  1       unsupported alu_op/func
//  ex_store_data  out  DATA_W  forwarded rt value for stores
//  ex_dest/ex_reg_write/ex_mem_read/ex_mem_write/ex_mem_to_reg  out  registered control
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): ex_valid=0, all registered data/control 0, stall_count=0; id_ready=1 next cycle.
//  - hazard = id_valid & ex_valid & ex_mem_read & ex_reg_write & ex_dest!=0 & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt)).
//  - id_ready = !hazard & (!ex_valid | ex_ready).
//  - Posedge priority: flush -> ex_valid=0 (data don't-care, accept suppressed);
//    else id_valid&id_ready -> capture all id_* fields, ex_valid=1, latency 1 cycle;
//    else ex_valid&ex_ready (incl. hazard) -> ex_valid=0 (bubble); else hold.
//  - Forwarding (combinational, per operand): if mem_reg_write & mem_dest==idx & idx!=0 -> mem_result;
//    else if wb_reg_write & wb_dest==idx & idx!=0 -> wb_data; else stored value. EX/MEM wins on double match.
//  - Held refresh: while ex_valid & !ex_ready, stored rs/rt values overwritten each cycle with forwarded values
//    so retiring producers are not lost.
//  - ex_in1 = fwd_rs; ex_in2 = alu_src ? imm : fwd_rt; ex_store_data = fwd_rt.
//  - ex_alu_ctl: op 00->0010; 01->0110; 10: func 100000->0010, 100010->0110, 100100->0000, 100101->0001,
//    101010->0111, 100111->1100; other func or op 11 -> 0000 with ex_illegal=1 (no X/Z driven).
//  - ex_illegal and ex_alu_ctl are registered with the instruction; outputs 0 when ex_valid=0.
//  - Register 0 never forwarded nor triggers hazard.
// CONFIGURATION
//  IDEX_STALL_CNT_EN defined: extra output stall_count[CNT_W-1:0]; +1 on every cycle hazard=1,
//    saturates at all-ones, cleared only by reset. Not defined: port and counter absent, behaviour otherwise identical.
// TESTING
//  - Reset: rst_n=0 two cycles -> ex_valid=0, ex_in1=0, ex_alu_ctl=0, id_ready=1.
//  - add R-type rs=3(5),rt=4(7),func=100000, ex_ready=1 -> next cycle ex_in1=5, ex_in2=7, ex_alu_ctl=0010.
//  - Forward: stage holds rs=8, mem_dest=8 mem_result=0x10, wb_dest=8 wb_data=0x20 -> ex_in1=0x10; rs=0 -> no forward.
//  - Load-use: lw dest=9 in stage, id add rs=9 -> id_ready=0 one cycle, bubble (ex_valid=0), then add accepted.
//  - Backpressure: ex_ready=0 three cycles, wb_dest=rt wb_data=0xAB in cycle 2 -> held, ex_in2=0xAB after release.
//  - flush with id_valid=1 -> ex_valid=0 next cycle; func=000000 op=10 -> ex_alu_ctl=0000, ex_illegal=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding, ALU control decode, load-use bubble.
// Optional IDEX_STALL_CNT_EN adds a saturating hazard-cycle counter (stall_count).
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_uses_rt,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_func,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_in1,
  output logic [DATA_W-1:0] ex_in2,
  output logic [3:0]        ex_alu_ctl,
  output logic              ex_illegal,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_count
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] rs_d;
    logic [DATA_W-1:0] rt_d;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              illegal;
    logic [3:0]        ctl;
  } id_ex_t;

  id_ex_t q;
  id_ex_t d;
  logic   v;

  logic       hazard;
  logic       accept;
  logic [3:0] dec_ctl;
  logic       dec_ill;

  logic              mem_hit_rs;
  logic              mem_hit_rt;
  logic              wb_hit_rs;
  logic              wb_hit_rt;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // Load in EX whose result a decoding instruction needs: one bubble.
  assign hazard = id_valid & v
                & q.mem_read & q.reg_write
                & (q.dest != '0)
                & ((q.dest == id_rs)
                 | (id_uses_rt & (q.dest == id_rt)));

  assign id_ready = !hazard & (!v | ex_ready);
  assign accept   = id_valid & id_ready;

  always_comb begin
    dec_ctl = 4'b0000;
    dec_ill = 1'b0;
    unique case (1'b1)
      id_alu_op == 2'b00: dec_ctl = 4'b0010;
      id_alu_op == 2'b01: dec_ctl = 4'b0110;
      id_alu_op == 2'b10: begin
        case (id_func)
          6'b100000: dec_ctl = 4'b0010;
          6'b100010: dec_ctl = 4'b0110;
          6'b100100: dec_ctl = 4'b0000;
          6'b100101: dec_ctl = 4'b0001;
          6'b101010: dec_ctl = 4'b0111;
          6'b100111: dec_ctl = 4'b1100;
          default:   dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    d            = '0;
    d.rs_d       = id_rs_data;
    d.rt_d       = id_rt_data;
    d.imm        = id_imm;
    d.rs         = id_rs;
    d.rt         = id_rt;
    d.dest       = id_dest;
    d.alu_src    = id_alu_src;
    d.reg_write  = id_reg_write;
    d.mem_read   = id_mem_read;
    d.mem_write  = id_mem_write;
    d.mem_to_reg = id_mem_to_reg;
    d.illegal    = dec_ill;
    d.ctl        = dec_ctl;
  end

  assign mem_hit_rs = mem_reg_write
                    & (mem_dest == q.rs)
                    & (q.rs != '0);
  assign mem_hit_rt = mem_reg_write
                    & (mem_dest == q.rt)
                    & (q.rt != '0);
  assign wb_hit_rs  = wb_reg_write
                    & (wb_dest == q.rs)
                    & (q.rs != '0);
  assign wb_hit_rt  = wb_reg_write
                    & (wb_dest == q.rt)
                    & (q.rt != '0);

  // EX/MEM is the younger producer, so it wins a double match.
  always_comb begin
    fwd_rs = q.rs_d;
    if (mem_hit_rs) begin
      fwd_rs = mem_result;
    end else if (wb_hit_rs) begin
      fwd_rs = wb_data;
    end
  end

  always_comb begin
    fwd_rt = q.rt_d;
    if (mem_hit_rt) begin
      fwd_rt = mem_result;
    end else if (wb_hit_rt) begin
      fwd_rt = wb_data;
    end
  end

  // While stalled, absorb forwarded values so retiring producers are kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= 1'b0;
      q <= '0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (accept) begin
      v <= 1'b1;
      q <= d;
    end else if (v && ex_ready) begin
      v <= 1'b0;
    end else if (v) begin
      q.rs_d <= fwd_rs;
      q.rt_d <= fwd_rt;
    end
  end

  assign ex_valid      = v;
  assign ex_in1        = fwd_rs;
  assign ex_in2        = q.alu_src ? q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_alu_ctl    = v ? q.ctl : 4'b0000;
  assign ex_illegal    = v & q.illegal;
  assign ex_dest       = q.dest;
  assign ex_reg_write  = q.reg_write;
  assign ex_mem_read   = q.mem_read;
  assign ex_mem_write  = q.mem_write;
  assign ex_mem_to_reg = q.mem_to_reg;

`ifdef IDEX_STALL_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (hazard && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_ONE;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instructions, monitor checks each retire.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_dest;
  logic        id_uses_rt;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_func;
  logic        id_alu_src;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic        flush;
  logic        ex_ready;
  logic        mem_reg_write;
  logic [4:0]  mem_dest;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_in1;
  logic [31:0] ex_in2;
  logic [3:0]  ex_alu_ctl;
  logic        ex_illegal;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
`ifdef IDEX_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_dest(id_dest), .id_uses_rt(id_uses_rt),
    .id_alu_op(id_alu_op), .id_func(id_func),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .flush(flush),
    .ex_ready(ex_ready),
    .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
    .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest),
    .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2),
    .ex_alu_ctl(ex_alu_ctl), .ex_illegal(ex_illegal),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
`ifdef IDEX_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] st;
    logic [3:0]  ctl;
    logic        ill;
    logic [4:0]  dest;
    logic [3:0]  cb;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every handshake out of the stage retires one scoreboard entry.
  always @(negedge clk) begin
    exp_t a;
    exp_t e;
    if (rst_n === 1'b1 && ex_valid === 1'b1 && ex_ready === 1'b1) begin
      a.in1  = ex_in1;
      a.in2  = ex_in2;
      a.st   = ex_store_data;
      a.ctl  = ex_alu_ctl;
      a.ill  = ex_illegal;
      a.dest = ex_dest;
      a.cb   = {ex_reg_write, ex_mem_read,
                ex_mem_write, ex_mem_to_reg};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected retire: got in1=%h in2=%h",
                 a.in1, a.in2);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL retire: got in1=%h in2=%h st=%h ctl=%b ill=%b dest=%0d cb=%b want in1=%h in2=%h st=%h ctl=%b ill=%b dest=%0d cb=%b",
                   a.in1, a.in2, a.st, a.ctl, a.ill, a.dest, a.cb,
                   e.in1, e.in2, e.st, e.ctl, e.ill, e.dest, e.cb);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // cb = {reg_write, mem_read, mem_write, mem_to_reg}
  task automatic drive(input logic [1:0]  op,
                       input logic [5:0]  fn,
                       input logic [4:0]  rs,
                       input logic [31:0] rsd,
                       input logic [4:0]  rt,
                       input logic [31:0] rtd,
                       input logic        ur,
                       input logic        src,
                       input logic [31:0] imm,
                       input logic [4:0]  dst,
                       input logic [3:0]  cb);
    id_alu_op     = op;
    id_func       = fn;
    id_rs         = rs;
    id_rs_data    = rsd;
    id_rt         = rt;
    id_rt_data    = rtd;
    id_uses_rt    = ur;
    id_alu_src    = src;
    id_imm        = imm;
    id_dest       = dst;
    id_reg_write  = cb[3];
    id_mem_read   = cb[2];
    id_mem_write  = cb[1];
    id_mem_to_reg = cb[0];
  endtask

  task automatic expect_out(input logic [31:0] in1,
                            input logic [31:0] in2,
                            input logic [31:0] st,
                            input logic [3:0]  ctl,
                            input logic        ill);
    exp_t e;
    e.in1  = in1;
    e.in2  = in2;
    e.st   = st;
    e.ctl  = ctl;
    e.ill  = ill;
    e.dest = id_dest;
    e.cb   = {id_reg_write, id_mem_read,
              id_mem_write, id_mem_to_reg};
    sb.push_back(e);
  endtask

  task automatic send(input string name);
    int n;
    n = 0;
    id_valid = 1'b1;
    @(negedge clk);
    while (id_ready !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({name, " accept"}, 32'(id_ready), 32'd1);
    step();
    id_valid = 1'b0;
  endtask

  logic [5:0] fns  [5] = '{6'b100100, 6'b100101, 6'b101010,
                           6'b100111, 6'b100010};
  logic [3:0] ctls [5] = '{4'b0000, 4'b0001, 4'b0111,
                           4'b1100, 4'b0110};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0;
    flush = 1'b0;
    ex_ready = 1'b1;
    mem_reg_write = 1'b0;
    mem_dest = '0;
    mem_result = '0;
    wb_reg_write = 1'b0;
    wb_dest = '0;
    wb_data = '0;
    drive(2'b00, 6'd0, 5'd0, 32'd0, 5'd0, 32'd0,
          1'b0, 1'b0, 32'd0, 5'd0, 4'b0000);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ex_valid", 32'(ex_valid), 32'd0);
    chk("rst ex_in1", ex_in1, 32'd0);
    chk("rst ex_alu_ctl", 32'(ex_alu_ctl), 32'd0);
    chk("rst ex_illegal", 32'(ex_illegal), 32'd0);
    chk("rst id_ready", 32'(id_ready), 32'd1);
    step();
    rst_n = 1'b1;

    // add r1 = r3(5) + r4(7)
    drive(2'b10, 6'b100000, 5'd3, 32'd5, 5'd4, 32'd7,
          1'b1, 1'b0, 32'd0, 5'd1, 4'b1000);
    expect_out(32'd5, 32'd7, 32'd7, 4'b0010, 1'b0);
    send("add");

    // sub with immediate operand
    drive(2'b01, 6'd0, 5'd2, 32'd100, 5'd6, 32'd9,
          1'b0, 1'b1, 32'd3, 5'd5, 4'b1000);
    expect_out(32'd100, 32'd3, 32'd9, 4'b0110, 1'b0);
    send("subi");

    for (int i = 0; i < 5; i++) begin
      drive(2'b10, fns[i], 5'd1, 32'hF0 + 32'(i), 5'd2, 32'h0F,
            1'b1, 1'b0, 32'd0, 5'd7, 4'b1000);
      expect_out(32'hF0 + 32'(i), 32'h0F, 32'h0F, ctls[i], 1'b0);
      send("rtype");
    end

    drive(2'b10, 6'b000000, 5'd1, 32'h11, 5'd2, 32'h22,
          1'b1, 1'b0, 32'd0, 5'd3, 4'b1000);
    expect_out(32'h11, 32'h22, 32'h22, 4'b0000, 1'b1);
    send("ill func");

    drive(2'b11, 6'b100000, 5'd1, 32'h33, 5'd2, 32'h44,
          1'b1, 1'b0, 32'd0, 5'd3, 4'b1000);
    expect_out(32'h33, 32'h44, 32'h44, 4'b0000, 1'b1);
    send("ill op");
    step();
    @(negedge clk);
    chk("idle ex_valid", 32'(ex_valid), 32'd0);
    chk("idle ex_illegal", 32'(ex_illegal), 32'd0);
    chk("idle ex_alu_ctl", 32'(ex_alu_ctl), 32'd0);

    // forwarding: EX/MEM over MEM/WB, then MEM/WB alone, then r0
    step();
    mem_reg_write = 1'b1;
    mem_dest = 5'd8;
    mem_result = 32'h10;
    wb_reg_write = 1'b1;
    wb_dest = 5'd8;
    wb_data = 32'h20;
    drive(2'b00, 6'd0, 5'd8, 32'h99, 5'd8, 32'h98,
          1'b1, 1'b0, 32'd0, 5'd2, 4'b1000);
    expect_out(32'h10, 32'h10, 32'h10, 4'b0010, 1'b0);
    send("fwd mem");
    step();
    mem_reg_write = 1'b0;
    drive(2'b00, 6'd0, 5'd8, 32'h99, 5'd4, 32'h44,
          1'b1, 1'b0, 32'd0, 5'd2, 4'b1000);
    expect_out(32'h20, 32'h44, 32'h44, 4'b0010, 1'b0);
    send("fwd wb");
    step();
    mem_reg_write = 1'b1;
    mem_dest = 5'd0;
    wb_dest = 5'd0;
    drive(2'b00, 6'd0, 5'd0, 32'h77, 5'd0, 32'h66,
          1'b1, 1'b0, 32'd0, 5'd2, 4'b1000);
    expect_out(32'h77, 32'h66, 32'h66, 4'b0010, 1'b0);
    send("fwd r0");
    step();
    mem_reg_write = 1'b0;
    wb_reg_write = 1'b0;

    // load-use: lw r9, then add reading r9
    drive(2'b00, 6'd0, 5'd1, 32'h100, 5'd0, 32'd0,
          1'b0, 1'b1, 32'd4, 5'd9, 4'b1101);
    expect_out(32'h100, 32'd4, 32'd0, 4'b0010, 1'b0);
    id_valid = 1'b1;
    @(negedge clk);
    chk("lw accept", 32'(id_ready), 32'd1);
    step();
    drive(2'b10, 6'b100000, 5'd9, 32'h200, 5'd3, 32'd5,
          1'b1, 1'b0, 32'd0, 5'd10, 4'b1000);
    wb_reg_write = 1'b1;
    wb_dest = 5'd9;
    wb_data = 32'h104;
    expect_out(32'h104, 32'd5, 32'd5, 4'b0010, 1'b0);
    @(negedge clk);
    chk("load-use stall", 32'(id_ready), 32'd0);
    step();
    @(negedge clk);
    chk("bubble ex_valid", 32'(ex_valid), 32'd0);
    chk("post-bubble ready", 32'(id_ready), 32'd1);
    step();
    id_valid = 1'b0;
    step();
    wb_reg_write = 1'b0;

    // backpressure with a MEM/WB producer retiring mid-stall
    ex_ready = 1'b0;
    drive(2'b10, 6'b100010, 5'd10, 32'd1, 5'd11, 32'd2,
          1'b1, 1'b0, 32'd0, 5'd12, 4'b1000);
    expect_out(32'd1, 32'hAB, 32'hAB, 4'b0110, 1'b0);
    send("bp");
    @(negedge clk);
    chk("bp id_ready", 32'(id_ready), 32'd0);
    chk("bp ex_valid", 32'(ex_valid), 32'd1);
    step();
    wb_reg_write = 1'b1;
    wb_dest = 5'd11;
    wb_data = 32'hAB;
    step();
    wb_reg_write = 1'b0;
    @(negedge clk);
    chk("bp refresh in2", ex_in2, 32'hAB);
    step();
    ex_ready = 1'b1;
    step();

    // flush kills a held instruction and suppresses the new one
    ex_ready = 1'b0;
    drive(2'b00, 6'd0, 5'd1, 32'h5, 5'd2, 32'h6,
          1'b1, 1'b0, 32'd0, 5'd3, 4'b1000);
    send("pre-flush");
    drive(2'b00, 6'd0, 5'd4, 32'h7, 5'd5, 32'h8,
          1'b1, 1'b0, 32'd0, 5'd6, 4'b1000);
    id_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    id_valid = 1'b0;
    ex_ready = 1'b1;
    @(negedge clk);
    chk("flush ex_valid", 32'(ex_valid), 32'd0);

`ifdef IDEX_STALL_CNT_EN
    chk("stall_count", 32'(stall_count), 32'd1);
`endif

    repeat (3) step();
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
